// File: rtl/counter_sched.sv
// Round-robin sequencer for a shared 8-bit counter: grants one timed interval at a time,
// clears the counter between intervals and cross-checks it against a shadow count.
module counter_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] len0,
  input  logic [7:0] len1,
  input  logic [7:0] cnt_val,
  output logic       cnt_rst,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       busy,
  output logic       err
);

  localparam int unsigned CW = 8;
  localparam int unsigned NR = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            id_q, id_d;
  logic            last_q, last_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   shadow_q, shadow_d;
  logic            err_q, err_d;
  logic            winner;

  logic            cnt_rst_d;
  logic [NR-1:0]   gnt_d, done_d;
  logic            busy_d;

  // Next-state, arbitration and datapath cross-check
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    last_d   = last_q;
    len_d    = len_q;
    shadow_d = shadow_q;
    err_d    = err_q;
    winner   = (req == 2'b11) ? ~last_q : req[1];

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d  = S_RUN;
          id_d     = winner;
          len_d    = winner ? len1 : len0;
          shadow_d = '0;
        end
      end
      S_RUN: begin
        shadow_d = shadow_q + CW'(1);
        if (cnt_val != shadow_q) err_d = 1'b1;
        // Abort takes priority over end-of-interval; len_q of 0 wraps to a compare against 255
        if (!req[id_q]) begin
          state_d = S_IDLE;
          last_d  = id_q;
        end else if (cnt_val == len_q - CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are precomputed from the next state so they leave the block registered
    gnt_d     = (state_d != S_IDLE) ? {id_d, ~id_d} : 2'b00;
    done_d    = (state_d == S_DONE) ? {id_d, ~id_d} : 2'b00;
    busy_d    = (state_d != S_IDLE);
    cnt_rst_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      len_q    <= '0;
      shadow_q <= '0;
      err_q    <= 1'b0;
      gnt      <= '0;
      done     <= '0;
      busy     <= 1'b0;
      cnt_rst  <= 1'b1;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      last_q   <= last_d;
      len_q    <= len_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
      gnt      <= gnt_d;
      done     <= done_d;
      busy     <= busy_d;
      cnt_rst  <= cnt_rst_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed bench for counter_sched with a behavioural counter and a done-pulse scoreboard.
module tb_counter_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] len0, len1;
  logic [7:0] cnt_val;
  logic       cnt_rst;
  logic [1:0] gnt, done;
  logic       busy, err;

  logic [7:0] cnt_q = 8'd0;
  logic       force_en;
  logic [7:0] force_val;

  typedef struct {
    logic [1:0]  id_oh;
    int unsigned n;
  } exp_t;

  exp_t exp_q[$];
  exp_t sb_e;
  int   run_cnt = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  counter_sched dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .len0    (len0),
    .len1    (len1),
    .cnt_val (cnt_val),
    .cnt_rst (cnt_rst),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Reference free-running counter with synchronous clear
  always @(posedge clk) begin
    if (cnt_rst) cnt_q <= 8'd0;
    else         cnt_q <= cnt_q + 8'd1;
  end

  assign cnt_val = force_en ? force_val : cnt_q;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // Scoreboard: every done pulse pops one expected interval (requester and RUN length)
  always @(negedge clk) begin
    if (rst || !busy) begin
      run_cnt = 0;
    end else if (done == 2'b00) begin
      run_cnt++;
    end else begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_done", 16'(done), 16'(0));
      end else begin
        sb_e = exp_q.pop_front();
        check("sb_done_id", 16'(done), 16'(sb_e.id_oh));
        check("sb_run_len", 16'(run_cnt), 16'(sb_e.n));
      end
      run_cnt = 0;
    end
  end

  initial begin
    rst = 1'b1; req = 2'b00; len0 = 8'd0; len1 = 8'd0;
    force_en = 1'b0; force_val = 8'd0;
    #2;
    check("rst_gnt",  16'(gnt),     16'(0));
    check("rst_done", 16'(done),    16'(0));
    check("rst_busy", 16'(busy),    16'(0));
    check("rst_crst", 16'(cnt_rst), 16'(1));
    check("rst_err",  16'(err),     16'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single interval, len0 = 5; a len0 change after the grant must be ignored
    req = 2'b01; len0 = 8'd5;
    exp_q.push_back('{id_oh: 2'b01, n: 5});
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) len0 = 8'd9;
      check("t1_gnt",  16'(gnt),     16'(2'b01));
      check("t1_cnt",  16'(cnt_val), 16'(i));
      check("t1_crst", 16'(cnt_rst), 16'(0));
    end
    tick();
    check("t1_done",      16'(done),    16'(2'b01));
    check("t1_done_gnt",  16'(gnt),     16'(2'b01));
    check("t1_done_crst", 16'(cnt_rst), 16'(1));
    req = 2'b00;
    tick();
    check("t1_idle_gnt",  16'(gnt),     16'(0));
    check("t1_idle_busy", 16'(busy),    16'(0));
    check("t1_idle_crst", 16'(cnt_rst), 16'(1));
    check("t1_err",       16'(err),     16'(0));

    // Contention from reset: grants alternate 0,1,0,1 with one IDLE cycle between
    do_reset();
    req = 2'b11; len0 = 8'd3; len1 = 8'd2;
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{id_oh: (k % 2 == 1) ? 2'b10 : 2'b01, n: (k % 2 == 1) ? 2 : 3});
    for (int k = 0; k < 4; k++) begin
      logic [1:0] oh;
      int         n;
      oh = (k % 2 == 1) ? 2'b10 : 2'b01;
      n  = (k % 2 == 1) ? 2 : 3;
      for (int c = 0; c < n; c++) begin
        tick();
        check("t2_gnt",  16'(gnt),  16'(oh));
        check("t2_busy", 16'(busy), 16'(1));
      end
      tick();
      check("t2_done", 16'(done), 16'(oh));
      tick();
      check("t2_gap_gnt", 16'(gnt), 16'(0));
      if (k == 3) req = 2'b00;
    end

    // Length 0 means 256 ticks; counter wraps only as the interval ends
    req = 2'b10; len1 = 8'd0;
    exp_q.push_back('{id_oh: 2'b10, n: 256});
    for (int i = 0; i < 256; i++) begin
      tick();
      if (i == 0 || i == 255) begin
        check("t3_cnt", 16'(cnt_val), 16'(i));
        check("t3_gnt", 16'(gnt),     16'(2'b10));
      end
    end
    tick();
    check("t3_done", 16'(done), 16'(2'b10));
    req = 2'b00;
    tick();
    check("t3_err",  16'(err),  16'(0));
    check("t3_busy", 16'(busy), 16'(0));

    // Abort in the 4th RUN cycle, then contested arbitration must favour requester 1
    req = 2'b01; len0 = 8'd10;
    for (int i = 0; i < 4; i++) tick();
    check("t4_gnt_run", 16'(gnt), 16'(2'b01));
    req = 2'b00;
    tick();
    check("t4_abort_gnt",  16'(gnt),  16'(0));
    check("t4_abort_done", 16'(done), 16'(0));
    check("t4_abort_busy", 16'(busy), 16'(0));
    req = 2'b11; len0 = 8'd3; len1 = 8'd2;
    exp_q.push_back('{id_oh: 2'b10, n: 2});
    tick();
    check("t4_regrant", 16'(gnt), 16'(2'b10));
    tick();
    tick();
    check("t4_done", 16'(done), 16'(2'b10));
    req = 2'b00;
    tick();

    // Forced datapath mismatch sets sticky err without disturbing the interval
    req = 2'b01; len0 = 8'd6;
    exp_q.push_back('{id_oh: 2'b01, n: 6});
    tick();
    check("t5_err_pre", 16'(err), 16'(0));
    tick();
    force_en = 1'b1; force_val = 8'd7;
    tick();
    force_en = 1'b0;
    check("t5_err_set", 16'(err), 16'(1));
    for (int i = 0; i < 3; i++) tick();
    tick();
    check("t5_done",     16'(done), 16'(2'b01));
    check("t5_err_done", 16'(err),  16'(1));
    req = 2'b00;
    tick();
    check("t5_err_idle", 16'(err), 16'(1));

    // Asynchronous reset between edges in the middle of RUN
    req = 2'b01; len0 = 8'd6;
    tick();
    tick();
    check("t6_busy_pre", 16'(busy), 16'(1));
    #2 rst = 1'b1;
    #1;
    check("t6_gnt",  16'(gnt),     16'(0));
    check("t6_done", 16'(done),    16'(0));
    check("t6_busy", 16'(busy),    16'(0));
    check("t6_crst", 16'(cnt_rst), 16'(1));
    check("t6_err",  16'(err),     16'(0));
    @(negedge clk);
    rst = 1'b0; req = 2'b00;
    tick();
    tick();

    check("sb_empty", 16'(exp_q.size()), 16'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
